// File: rtl/result_serializer_if.sv
// Result-serializer signal bundle: FPU result capture, off-chip req/ack pins and status.
// The master side drives results and the reader acknowledge; the slave side is the serializer.
interface result_serializer_if;
    logic [15:0] ans;
    logic        done_calc;
    logic        ack;
    logic [9:0]  data_out;
    logic        busy;
    logic        overflow;

    modport master (
        output ans, done_calc, ack,
        input  data_out, busy, overflow
    );

    modport slave (
        input  ans, done_calc, ack,
        output data_out, busy, overflow
    );
endinterface

// File: rtl/result_serializer.sv
// Buffers 16-bit FPU results in a FIFO and ships each as two byte beats over a four-phase req/ack pin set.
// Optional RESULT_SER_OVERWRITE_EN: a result arriving while full overwrites the oldest entry instead of being dropped.
module result_serializer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                clock,
    input  logic                reset,
    result_serializer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI_REQ,
        S_HI_REL,
        S_LO_REQ,
        S_LO_REL
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_ack_meta, r_ack_s;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_hold, w_hold_nxt;
    logic [9:0]       r_data_out, w_data_nxt;
    logic             r_overflow;
    logic             w_full, w_pop, w_push, w_over, w_wr, w_rd_adv;

    assign w_full = (r_count == FULL_CNT);
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
    assign w_push = bus.done_calc && (!w_full || w_pop);
    assign w_over = bus.done_calc && w_full && !w_pop;

`ifdef RESULT_SER_OVERWRITE_EN
    // Overwrite keeps count at DEPTH: the write lands on the oldest slot and the read side skips past it.
    assign w_wr     = w_push || w_over;
    assign w_rd_adv = w_pop || w_over;
`else
    assign w_wr     = w_push;
    assign w_rd_adv = w_pop;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_data_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = S_HI_REQ;
                    w_hold_nxt  = r_mem[r_rptr];
                end
            end
            S_HI_REQ: if (r_ack_s)  w_state_nxt = S_HI_REL;
            S_HI_REL: if (!r_ack_s) w_state_nxt = S_LO_REQ;
            S_LO_REQ: if (r_ack_s)  w_state_nxt = S_LO_REL;
            S_LO_REL: if (!r_ack_s) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        // Output pins are registered from the next state so they line up with the state register.
        case (w_state_nxt)
            S_HI_REQ: w_data_nxt = {1'b1, 1'b0, w_hold_nxt[15:8]};
            S_HI_REL: w_data_nxt = {1'b0, 1'b0, w_hold_nxt[15:8]};
            S_LO_REQ: w_data_nxt = {1'b1, 1'b1, w_hold_nxt[7:0]};
            S_LO_REL: w_data_nxt = {1'b0, 1'b1, w_hold_nxt[7:0]};
            default:  w_data_nxt = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
            r_state    <= S_IDLE;
            r_hold     <= '0;
            r_data_out <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_ack_meta <= bus.ack;
            r_ack_s    <= r_ack_meta;
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_data_out <= w_data_nxt;
            if (w_wr)
                r_wptr <= r_wptr + PW'(1);
            if (w_rd_adv)
                r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
            if (w_over)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_wr)
            r_mem[r_wptr] <= bus.ans;
    end

    assign bus.data_out = r_data_out;
    assign bus.busy     = (r_count != '0) || (r_state != S_IDLE);
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer: vector table, hand-built corner sequences
// and randomized bursts compared against a queue-level model of buffering and drop/overwrite.
module tb_result_serializer;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset;
    result_serializer_if bus();

    result_serializer #(.DEPTH(DEPTH), .WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    bit          rd_en;
    int          rd_delay;
    int          rd_cnt;
    bit          prev_req;
    bit          saw_idle;
    bit          have_hi;
    logic [7:0]  hi_byte;
    logic [8:0]  latched;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] push_q[$];

    typedef struct packed {
        int               n;
        logic [0:5][15:0] w;
        int               en;
        logic [0:5][15:0] e;
        bit               ovf;
        int               dly;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic reader_step();
        logic req;
        req = bus.data_out[9];
        if (req && !prev_req) begin
            if (!bus.data_out[8]) begin
                check("idle_gap_before_word", saw_idle, 1'b1);
                check("beat_hi_first", have_hi, 1'b0);
                saw_idle = 1'b0;
                hi_byte  = bus.data_out[7:0];
                have_hi  = 1'b1;
            end else begin
                check("beat_lo_after_hi", have_hi, 1'b1);
                got_q.push_back({hi_byte, bus.data_out[7:0]});
                have_hi = 1'b0;
            end
            latched = bus.data_out[8:0];
        end else if (bus.data_out != 10'h000) begin
            check("data_stable", bus.data_out[8:0], latched);
        end
        if (bus.data_out == 10'h000) saw_idle = 1'b1;
        prev_req = req;
        if (req && !bus.ack) begin
            if (rd_cnt >= rd_delay) begin bus.ack = 1'b1; rd_cnt = 0; end
            else rd_cnt++;
        end else if (!req && bus.ack) begin
            if (rd_cnt >= rd_delay) begin bus.ack = 1'b0; rd_cnt = 0; end
            else rd_cnt++;
        end else begin
            rd_cnt = 0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (rd_en) reader_step();
    endtask

    task automatic reader_reset();
        rd_cnt   = 0;
        prev_req = 1'b0;
        saw_idle = 1'b1;
        have_hi  = 1'b0;
        got_q.delete();
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.done_calc = 1'b0;
        bus.ack       = 1'b0;
        bus.ans       = '0;
        rd_en         = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        reader_reset();
    endtask

    task automatic push(input logic [15:0] w);
        bus.ans       = w;
        bus.done_calc = 1'b1;
        tick();
        bus.done_calc = 1'b0;
    endtask

    task automatic drain(input int dly);
        int k;
        rd_delay = dly;
        rd_en    = 1'b1;
        k        = 0;
        tick();
        while (!(bus.busy == 1'b0 && bus.data_out == 10'h000 && bus.ack == 1'b0) && k < 3000) begin
            tick();
            k++;
        end
        check("drain_timeout", k >= 3000, 1'b0);
        check("drain_half_word", have_hi, 1'b0);
        rd_en = 1'b0;
    endtask

    task automatic ack_phase(input logic v, input logic [9:0] prev, input logic [9:0] nxt);
        bus.ack = v;
        tick();
        tick();
        check($sformatf("hold_%03h", prev), bus.data_out, prev);
        tick();
        check($sformatf("phase_to_%03h", nxt), bus.data_out, nxt);
    endtask

    task automatic compare_words(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_word%0d", name, i), got_q[i], exp_q[i]);
    endtask

    // One word leaves immediately; DEPTH more can wait; extras are dropped or displace the oldest.
    task automatic model_expect();
        logic [15:0] rest[$];
        exp_q.delete();
        if (push_q.size() == 0) return;
        exp_q.push_back(push_q[0]);
        for (int i = 1; i < push_q.size(); i++) rest.push_back(push_q[i]);
`ifdef RESULT_SER_OVERWRITE_EN
        while (rest.size() > DEPTH) void'(rest.pop_front());
`else
        while (rest.size() > DEPTH) void'(rest.pop_back());
`endif
        foreach (rest[i]) exp_q.push_back(rest[i]);
    endtask

    initial begin
        tbl[0] = '{1, {16'h3C00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                   1, {16'h3C00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 1'b0, 3};
        tbl[1] = '{3, {16'h4000, 16'hC200, 16'h7BFF, 16'h0, 16'h0, 16'h0},
                   3, {16'h4000, 16'hC200, 16'h7BFF, 16'h0, 16'h0, 16'h0}, 1'b0, 0};
`ifdef RESULT_SER_OVERWRITE_EN
        tbl[2] = '{6, {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006},
                   5, {16'h0001, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0}, 1'b1, 1};
`else
        tbl[2] = '{6, {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006},
                   5, {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0}, 1'b1, 1};
`endif
        tbl[3] = '{5, {16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'h0},
                   5, {16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'h0}, 1'b0, 2};

        do_reset();
        check("reset_data_out", bus.data_out, 10'h000);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_overflow", bus.overflow, 1'b0);

        // Table vectors: burst with the reader stalled, then drain.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int j = 0; j < tbl[v].n; j++) push(tbl[v].w[j]);
            drain(tbl[v].dly);
            check($sformatf("vec%0d_overflow", v), bus.overflow, tbl[v].ovf);
            exp_q.delete();
            for (int j = 0; j < tbl[v].en; j++) exp_q.push_back(tbl[v].e[j]);
            compare_words($sformatf("vec%0d", v));
        end

        // Exact pin timeline for a single word with a manual reader.
        do_reset();
        push(16'h3C00);
        check("lat_cycle1_data", bus.data_out, 10'h000);
        check("lat_cycle1_busy", bus.busy, 1'b1);
        tick();
        check("lat_cycle2_data", bus.data_out, 10'h23C);
        tick(); tick(); tick();
        check("req_waits_ack", bus.data_out, 10'h23C);
        ack_phase(1'b1, 10'h23C, 10'h03C);
        ack_phase(1'b0, 10'h03C, 10'h300);
        ack_phase(1'b1, 10'h300, 10'h100);
        ack_phase(1'b0, 10'h100, 10'h000);
        check("timeline_busy_end", bus.busy, 1'b0);

        // Push in the same cycle as an IDLE pop while full: nothing is lost.
        do_reset();
        push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444); push(16'h5555);
        check("full_no_ovf", bus.overflow, 1'b0);
        ack_phase(1'b1, 10'h211, 10'h011);
        ack_phase(1'b0, 10'h011, 10'h311);
        ack_phase(1'b1, 10'h311, 10'h111);
        ack_phase(1'b0, 10'h111, 10'h000);
        push(16'h6666);
        check("simul_pushpop_ovf", bus.overflow, 1'b0);
        reader_reset();
        drain(0);
        exp_q = '{16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
        compare_words("simul");
        check("simul_ovf_after", bus.overflow, 1'b0);

        // Reset in LO_REQ discards everything.
        do_reset();
        push(16'h1234); push(16'h5678); push(16'h9ABC);
        ack_phase(1'b1, 10'h212, 10'h012);
        ack_phase(1'b0, 10'h012, 10'h334);
        reset = 1'b1;
        tick();
        check("midreset_data", bus.data_out, 10'h000);
        check("midreset_busy", bus.busy, 1'b0);
        check("midreset_ovf", bus.overflow, 1'b0);
        reset = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (bus.data_out != 10'h000 || bus.busy) seen = 1'b1;
            end
            check("midreset_no_emit", seen, 1'b0);
        end

        // Ten single words to walk both pointers around the FIFO.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            got_q.delete();
            push(w);
            drain(int'($urandom_range(0, 2)));
            exp_q = '{w};
            compare_words($sformatf("wrap%0d", i));
        end

        // Randomized bursts against the queue model.
        for (int r = 0; r < 20; r++) begin
            int n;
            do_reset();
            push_q.delete();
            n = int'($urandom_range(1, 7));
            for (int j = 0; j < n; j++) begin
                logic [15:0] w;
                w = 16'($urandom);
                push_q.push_back(w);
                push(w);
                repeat ($urandom_range(0, 2)) tick();
            end
            model_expect();
            drain(int'($urandom_range(0, 3)));
            check($sformatf("rand%0d_overflow", r), bus.overflow, (n - 1) > DEPTH);
            compare_words($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
